keypad_matrix_emulator: RTL

//  Drive end of the 4x4 matrix-keypad interface: answers the column scan with row levels, as a physical keypad does.

---
 rtl/keypad_matrix_emulator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_emulator.sv
// Emulates a 4x4 matrix keypad: queued key codes are "pressed" for HOLD_CYCLES and
// "released" for GAP_CYCLES, with row levels answered live from the scanner's column drive.
module keypad_matrix_emulator #(
   parameter int unsigned HOLD_CYCLES = 2_700_000,
   parameter int unsigned GAP_CYCLES  = 2_700_000,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                columnas,
   input  logic [3:0]                key_code,
   input  logic                      key_valid,
   output logic                      key_ready,
   output logic [3:0]                filas,
   output logic                      busy,
   output logic                      key_done,
   output logic [$clog2(DEPTH):0]    fifo_level
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESS   = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cur_row_q, cur_row_d;
   logic [1:0]    cur_col_q, cur_col_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          key_ready_q, key_ready_d;
   logic          busy_q, busy_d;
   logic          key_done_q, key_done_d;
   logic          push, pop;
   logic [3:0]    mem [DEPTH];

   // Key code -> {row, col} position in the physical matrix
   function automatic logic [3:0] key_pos(input logic [3:0] code);
      case (code)
         4'h1: key_pos = {2'd0, 2'd0};
         4'h2: key_pos = {2'd0, 2'd1};
         4'h3: key_pos = {2'd0, 2'd2};
         4'hA: key_pos = {2'd0, 2'd3};
         4'h4: key_pos = {2'd1, 2'd0};
         4'h5: key_pos = {2'd1, 2'd1};
         4'h6: key_pos = {2'd1, 2'd2};
         4'hB: key_pos = {2'd1, 2'd3};
         4'h7: key_pos = {2'd2, 2'd0};
         4'h8: key_pos = {2'd2, 2'd1};
         4'h9: key_pos = {2'd2, 2'd2};
         4'hC: key_pos = {2'd2, 2'd3};
         4'hE: key_pos = {2'd3, 2'd0};
         4'h0: key_pos = {2'd3, 2'd1};
         4'hF: key_pos = {2'd3, 2'd2};
         default: key_pos = {2'd3, 2'd3};
      endcase
   endfunction

   // Next-state, FIFO bookkeeping and registered-output precompute
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_row_d   = cur_row_q;
      cur_col_d   = cur_col_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      push        = key_valid && key_ready_q;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop                    = 1'b1;
               {cur_row_d, cur_col_d} = key_pos(mem[rd_ptr_q]);
               cnt_d                  = '0;
               state_d                = PRESS;
            end
         end
         PRESS: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);

      // key_done is high for the final gap cycle, registered alongside the state
      key_ready_d = (level_d != LEVEL_FULL);
      busy_d      = (state_d != IDLE) || (level_d != '0);
      key_done_d  = (state_d == RELEASE) && (cnt_d == GAP_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cur_row_q   <= '0;
         cur_col_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         key_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         key_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_row_q   <= cur_row_d;
         cur_col_q   <= cur_col_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
         key_done_q  <= key_done_d;
      end
   end

   // FIFO storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= key_code;
   end

   // Row levels follow the live column drive with no clock, like a real switch
   always_comb begin
      filas = 4'b0000;
      if ((state_q == PRESS) && columnas[cur_col_q]) filas[cur_row_q] = 1'b1;
   end

   assign key_ready  = key_ready_q;
   assign busy       = busy_q;
   assign key_done   = key_done_q;
   assign fifo_level = level_q;

endmodule
